// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the micro-coded control sequencer: opcodes, FSM encoding,
// step indices and control-word bit positions.
package control_sequencer_pkg;

    localparam int unsigned SIG_W = 17;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH0 = 2'd0,
        ST_FETCH1 = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Bit positions in the control word, MSB first.
    localparam int unsigned B_HLT = 16;
    localparam int unsigned B_WE  = 15;
    localparam int unsigned B_OE  = 14;
    localparam int unsigned B_MI  = 13;
    localparam int unsigned B_AI  = 12;
    localparam int unsigned B_BI  = 11;
    localparam int unsigned B_AO  = 10;
    localparam int unsigned B_BO  = 9;
    localparam int unsigned B_EO  = 8;
    localparam int unsigned B_SUB = 7;
    localparam int unsigned B_OI  = 6;
    localparam int unsigned B_CE  = 5;
    localparam int unsigned B_J   = 4;
    localparam int unsigned B_CO  = 3;
    localparam int unsigned B_II  = 2;
    localparam int unsigned B_IO  = 1;
    localparam int unsigned B_FI  = 0;

    function automatic logic [SIG_W-1:0] sig_bit(input int unsigned idx);
        sig_bit = 17'd1 << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational microcode ROM: maps step index and opcode (plus flags at T2)
// to the control word and end-of-instruction markers.
module control_decode
    import control_sequencer_pkg::*;
(
    input  logic [2:0]       micro_i,
    input  logic [3:0]       opcode_i,
    input  logic             fz_i,
    input  logic             fc_i,
    output logic [SIG_W-1:0] signals_o,
    output logic             last_step_o,
    output logic             is_hlt_o
);

    // Microcode lookup per step and opcode.
    always_comb begin
        signals_o   = 17'd0;
        last_step_o = 1'b0;
        is_hlt_o    = (opcode_i == OP_HLT);
        case (micro_i)
            T0: begin
                signals_o = sig_bit(B_CO) | sig_bit(B_MI);
            end
            T1: begin
                signals_o = sig_bit(B_OE) | sig_bit(B_II) | sig_bit(B_CE);
            end
            T2: begin
                last_step_o = 1'b1;
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        signals_o   = sig_bit(B_IO) | sig_bit(B_MI);
                        last_step_o = 1'b0;
                    end
                    OP_LDI: signals_o = sig_bit(B_IO) | sig_bit(B_AI);
                    OP_JMP: signals_o = sig_bit(B_IO) | sig_bit(B_J);
                    OP_JC: begin
                        if (fc_i) begin
                            signals_o = sig_bit(B_IO) | sig_bit(B_J);
                        end else begin
                            signals_o = 17'd0;
                        end
                    end
                    OP_JZ: begin
                        if (fz_i) begin
                            signals_o = sig_bit(B_IO) | sig_bit(B_J);
                        end else begin
                            signals_o = 17'd0;
                        end
                    end
                    OP_OUT: signals_o = sig_bit(B_AO) | sig_bit(B_OI);
                    OP_HLT: signals_o = sig_bit(B_HLT);
                    default: signals_o = 17'd0;
                endcase
            end
            T3: begin
                last_step_o = 1'b1;
                case (opcode_i)
                    OP_LDA: signals_o = sig_bit(B_OE) | sig_bit(B_AI);
                    OP_ADD, OP_SUB: begin
                        signals_o   = sig_bit(B_OE) | sig_bit(B_BI);
                        last_step_o = 1'b0;
                    end
                    OP_STA: signals_o = sig_bit(B_AO) | sig_bit(B_WE);
                    default: signals_o = 17'd0;
                endcase
            end
            T4: begin
                last_step_o = 1'b1;
                case (opcode_i)
                    OP_ADD: signals_o = sig_bit(B_EO) | sig_bit(B_AI) | sig_bit(B_FI);
                    OP_SUB: signals_o = sig_bit(B_EO) | sig_bit(B_AI) | sig_bit(B_SUB) | sig_bit(B_FI);
                    default: signals_o = 17'd0;
                endcase
            end
            // Unreachable steps terminate so the sequencer always returns to fetch.
            default: begin
                signals_o   = 17'd0;
                last_step_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: fetch/execute/halt FSM, step counter and retired
// instruction counter; control words come from control_decode.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [3:0]       opcode,
    input  logic             FZ,
    input  logic             FC,
    output logic [SIG_W-1:0] signals,
    output logic [2:0]       micro,
    output logic             halted,
    output logic             instr_done,
    output logic [7:0]       instr_count
);

    state_e           state_q, state_d;
    logic [2:0]       micro_q, micro_d;
    logic [7:0]       count_q, count_d;
    logic [SIG_W-1:0] dec_signals_s;
    logic             last_step_s;
    logic             is_hlt_s;

    control_decode u_decode (
        .micro_i     (micro_q),
        .opcode_i    (opcode),
        .fz_i        (FZ),
        .fc_i        (FC),
        .signals_o   (dec_signals_s),
        .last_step_o (last_step_s),
        .is_hlt_o    (is_hlt_s)
    );

    // State, step and retire-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH0;
            micro_q <= T0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            micro_q <= micro_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; nothing moves while ce is low.
    always_comb begin
        state_d = state_q;
        micro_d = micro_q;
        count_d = count_q;
        if (ce) begin
            case (state_q)
                ST_FETCH0: begin
                    state_d = ST_FETCH1;
                    micro_d = T1;
                end
                ST_FETCH1: begin
                    state_d = ST_EXEC;
                    micro_d = T2;
                end
                ST_EXEC: begin
                    if (last_step_s) begin
                        state_d = is_hlt_s ? ST_HALT : ST_FETCH0;
                        micro_d = T0;
                    end else begin
                        micro_d = micro_q + 3'd1;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                    micro_d = T0;
                end
                default: begin
                    state_d = ST_FETCH0;
                    micro_d = T0;
                end
            endcase
            if (instr_done) begin
                count_d = count_q + 8'd1;
            end else begin
                count_d = count_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output mapping; HALT overrides the decoded word with HLT alone.
    always_comb begin
        halted      = (state_q == ST_HALT);
        instr_done  = (state_q == ST_EXEC) && last_step_s;
        micro       = micro_q;
        instr_count = count_q;
        if (state_q == ST_HALT) begin
            signals = sig_bit(B_HLT);
        end else begin
            signals = dec_signals_s;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer with hand-computed control words.
module tb_control_sequencer;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [3:0]  opcode;
    logic        FZ;
    logic        FC;
    logic [16:0] signals;
    logic [2:0]  micro;
    logic        halted;
    logic        instr_done;
    logic [7:0]  instr_count;

    int n_tests;
    int n_fail;
    int exp_count;

    // Hand-computed control words (bit 16 = HLT ... bit 0 = FI).
    localparam logic [16:0] W_T0     = 17'h02008; // CO,MI
    localparam logic [16:0] W_T1     = 17'h04024; // OE,II,CE
    localparam logic [16:0] W_IO_MI  = 17'h02002;
    localparam logic [16:0] W_OE_BI  = 17'h04800;
    localparam logic [16:0] W_ADD4   = 17'h01101; // EO,AI,FI
    localparam logic [16:0] W_SUB4   = 17'h01181; // EO,AI,SUB,FI
    localparam logic [16:0] W_STA3   = 17'h08400; // AO,WE
    localparam logic [16:0] W_LDA3   = 17'h05000; // OE,AI
    localparam logic [16:0] W_JUMP   = 17'h00012; // IO,J
    localparam logic [16:0] W_OUT    = 17'h00440; // AO,OI
    localparam logic [16:0] W_HLT    = 17'h10000;
    localparam logic [16:0] W_NONE   = 17'h00000;

    control_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .opcode      (opcode),
        .FZ          (FZ),
        .FC          (FC),
        .signals     (signals),
        .micro       (micro),
        .halted      (halted),
        .instr_done  (instr_done),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_step(input string tag, input logic [2:0] m, input logic [16:0] w, input logic d);
        check_val({tag, ".micro"}, {29'd0, micro}, {29'd0, m});
        check_val({tag, ".signals"}, {15'd0, signals}, {15'd0, w});
        check_val({tag, ".done"}, {31'd0, instr_done}, {31'd0, d});
        check_val({tag, ".count"}, {24'd0, instr_count}, exp_count);
    endtask

    // Runs the two fetch steps and lands on T2 of the current opcode.
    task automatic fetch(input string tag);
        step();
        expect_step({tag, ".T1"}, 3'd1, W_T1, 1'b0);
        step();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_count = 0;
        rst = 1'b1; ce = 1'b0; opcode = 4'h2; FZ = 1'b0; FC = 1'b0;
        step();
        step();
        expect_step("reset", 3'd0, W_T0, 1'b0);
        check_val("reset.halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        ce  = 1'b1;

        // ADD: five-cycle instruction
        fetch("add");
        expect_step("add.T2", 3'd2, W_IO_MI, 1'b0);
        step(); expect_step("add.T3", 3'd3, W_OE_BI, 1'b0);
        step(); expect_step("add.T4", 3'd4, W_ADD4, 1'b1);
        step(); exp_count++;
        expect_step("add.ret", 3'd0, W_T0, 1'b0);

        // SUB: T4 adds SUB
        opcode = 4'h3;
        fetch("sub");
        step(); step(); expect_step("sub.T4", 3'd4, W_SUB4, 1'b1);
        step(); exp_count++;

        // JC not taken, then taken
        opcode = 4'h7; FC = 1'b0;
        fetch("jc0");
        expect_step("jc0.T2", 3'd2, W_NONE, 1'b1);
        step(); exp_count++;
        expect_step("jc0.ret", 3'd0, W_T0, 1'b0);
        FC = 1'b1;
        fetch("jc1");
        expect_step("jc1.T2", 3'd2, W_JUMP, 1'b1);
        step(); exp_count++;

        // JZ taken, OUT, reserved opcode as NOP
        opcode = 4'h8; FZ = 1'b1; FC = 1'b0;
        fetch("jz1");
        expect_step("jz1.T2", 3'd2, W_JUMP, 1'b1);
        step(); exp_count++;
        opcode = 4'hE;
        fetch("out");
        expect_step("out.T2", 3'd2, W_OUT, 1'b1);
        step(); exp_count++;
        opcode = 4'hB;
        fetch("rsv");
        expect_step("rsv.T2", 3'd2, W_NONE, 1'b1);
        step(); exp_count++;

        // STA stalled at T3 for five cycles
        opcode = 4'h4;
        fetch("sta");
        expect_step("sta.T2", 3'd2, W_IO_MI, 1'b0);
        step(); expect_step("sta.T3", 3'd3, W_STA3, 1'b1);
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_step("sta.stall", 3'd3, W_STA3, 1'b1);
        end
        ce = 1'b1;
        step(); exp_count++;
        expect_step("sta.resume", 3'd0, W_T0, 1'b0);

        // HLT then sticky HALT
        opcode = 4'hF;
        fetch("hlt");
        expect_step("hlt.T2", 3'd2, W_HLT, 1'b1);
        step(); exp_count++;
        expect_step("halt", 3'd0, W_HLT, 1'b0);
        check_val("halt.halted", {31'd0, halted}, 32'd1);
        opcode = 4'h2;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_step("halt.sticky", 3'd0, W_HLT, 1'b0);
            check_val("halt.sticky.halted", {31'd0, halted}, 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        exp_count = 0;
        expect_step("halt.rst", 3'd0, W_T0, 1'b0);
        check_val("halt.rst.halted", {31'd0, halted}, 32'd0);
        step();
        rst = 1'b0;

        // 256 LDI instructions wrap the retire counter
        opcode = 4'h5;
        for (int i = 0; i < 256; i++) begin
            step(); step();
            if (i == 0) begin
                expect_step("ldi.T2", 3'd2, 17'h01002, 1'b1);
            end
            step();
            exp_count = (exp_count + 1) % 256;
            if (i == 254) begin
                check_val("ldi.count255", {24'd0, instr_count}, 32'd255);
            end
        end
        expect_step("ldi.wrap", 3'd0, W_T0, 1'b0);

        // LDA aborted by async reset mid-T3
        opcode = 4'h1;
        fetch("lda");
        step(); expect_step("lda.T3", 3'd3, W_LDA3, 1'b1);
        #2 rst = 1'b1;
        #1;
        exp_count = 0;
        expect_step("lda.rst", 3'd0, W_T0, 1'b0);
        step();
        rst = 1'b0;
        step();
        expect_step("lda.release", 3'd1, W_T1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and reset: clk input 1, rising-edge system clock; rst input 1, asynchronous active-high reset.
REQ-002 The block SHALL have input ce, 1 bit: advance enable; when 0, all state holds and signals stay at their current-step values.
REQ-003 The block SHALL have input opcode, 4 bits: instruction register upper nibble, valid from step T2 onward.
REQ-004 The block SHALL have inputs FZ and FC, 1 bit each: registered zero and carry flags.
REQ-005 The block SHALL have output signals, 17 bits, ordered {HLT, WE, OE, MI, AI, BI, AO, BO, EO, SUB, OI, CE, J, CO, II, IO, FI}, MSB first.
REQ-006 The block SHALL have output micro, 3 bits: current step index, T0=0 through T4=4.
REQ-007 The block SHALL have output halted, 1 bit: high while in HALT.
REQ-008 The block SHALL have output instr_done, 1 bit: high during the last step of each instruction.
REQ-009 The block SHALL have output instr_count, 8 bits: count of retired instructions.

Function
REQ-010 The FSM SHALL have the states FETCH0 (T0), FETCH1 (T1), EXEC (T2..T4) and HALT.
REQ-011 Transitions SHALL occur only on rising clk edges with ce=1.
REQ-012 Transitions SHALL follow FETCH0->FETCH1->EXEC(T2), EXEC then steps or returns to FETCH0 after the last step, HLT at T2 goes to HALT, and HALT is sticky until rst.
REQ-013 signals SHALL be a combinational function of (state, micro, opcode, FZ, FC); unlisted bits SHALL be 0.
REQ-014 T0 SHALL assert CO, MI; T1 SHALL assert OE, II, CE for every instruction.
REQ-015 Execute steps by opcode SHALL be (last step = end):
  - 0x0 NOP: T2 none, end.
  - 0x1 LDA: T2 IO,MI; T3 OE,AI, end.
  - 0x2 ADD: T2 IO,MI; T3 OE,BI; T4 EO,AI,FI, end.
  - 0x3 SUB: T2 IO,MI; T3 OE,BI; T4 EO,AI,SUB,FI, end.
  - 0x4 STA: T2 IO,MI; T3 AO,WE, end.
  - 0x5 LDI: T2 IO,AI, end.
  - 0x6 JMP: T2 IO,J, end.
  - 0x7 JC: T2 IO,J if FC=1 else none, end.
  - 0x8 JZ: T2 IO,J if FZ=1 else none, end.
  - 0xE OUT: T2 AO,OI, end.
  - 0xF HLT: T2 HLT, end, then HALT.
  - 0x9..0xD: treated as NOP.
REQ-016 Instruction length SHALL be 3 cycles (NOP, LDI, JMP, JC, JZ, OUT, HLT), 4 cycles (LDA, STA) or 5 cycles (ADD, SUB); no idle steps.
REQ-017 FZ and FC SHALL be sampled combinationally during T2 only.
REQ-018 instr_done SHALL be high during the end step of each instruction; micro SHALL equal that step's index.
REQ-019 instr_count SHALL increment by 1 on each edge where instr_done=1 and ce=1, including HLT, and SHALL wrap from 255 to 0.
REQ-020 In HALT: signals SHALL be {HLT=1, all others 0}, micro=0, halted=1, instr_done=0, and instr_count SHALL hold.
REQ-021 When ce=0, a held step SHALL keep the same signals output every cycle, so that WE or FI remains asserted while stalled.

Reset
REQ-022 rst=1 SHALL force, asynchronously, state=FETCH0, micro=0, instr_count=0, halted=0.
REQ-023 Reset values SHALL give signals={CO,MI} only and instr_done=0.
REQ-024 Reset asserted mid-instruction or in HALT SHALL abort the instruction with no partial step completed after release.
REQ-025 The first active edge after reset release SHALL move the FSM to FETCH1.

Structure
REQ-026 A shared package SHALL hold the opcode constants, state encoding, step constants T0..T4, and the 17 signal-bit index constants.
REQ-027 One sub-module, control_decode, SHALL be combinational and map (micro, opcode, FZ, FC) to {signals, last_step, is_hlt}.
REQ-028 The sequencer SHALL hold only the FSM, the step counter and instr_count.

Verification
REQ-029 Scenario 1: reset, then ce=1 with opcode=0x2 from T2 -> micro 0,1,2,3,4,0; T4 signals have EO,AI,FI=1, SUB=0; instr_done high only at T4; instr_count=1.
REQ-030 Scenario 2: opcode=0x7 with FC=0 -> T2 signals all 0, 3-cycle instruction; repeat with FC=1 -> T2 has IO,J=1.
REQ-031 Scenario 3: opcode=0xF -> T2 HLT=1, then halted=1 permanently with signals=HLT only; a later opcode change has no effect; rst clears it.
REQ-032 Scenario 4: opcode=0x4, drop ce at T3 for 5 cycles -> AO,WE held for all 5 cycles, micro stays 3; resumes to T0 after ce=1.
REQ-033 Scenario 5: 256 opcode=0x5 instructions -> instr_count wraps to 0; a mid-T3 async rst of an LDA -> immediately micro=0, signals={CO,MI}.
